ysyx_25040111_arb: RTL

YSYX_25040111_ARB -- requirements
Module: ysyx_25040111_arb

---
 rtl/ysyx_25040111_arb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040111_arb.sv
`default_nettype none
// ============================================================================
// ysyx_25040111_arb : IFU/LSU arbiter onto one memory port; tie-break is
// round-robin when YSYX_ARB_RR_EN is defined, LSU-first otherwise. Rev 1.0
// ============================================================================
module ysyx_25040111_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_write,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_mask,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_resp
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  localparam logic c_own_ifu = 1'b0;
  localparam logic c_own_lsu = 1'b1;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic        r_owner;
  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [1:0]  r_mask;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_gnt_ifu;
  logic        w_gnt_lsu;
  logic        w_idle;
  logic        w_accept;
  logic        w_lsu_misalign;
  logic        w_ifu_misalign;
  logic        w_misaligned;
  logic        w_resp;
  logic [3:0]  w_strb_base;

`ifdef YSYX_ARB_RR_EN
  // Pointer 0 lets LSU win a tie, 1 lets IFU win; it flips to the other side on every grant.
  logic r_rr_ptr;

  always_comb begin
    w_gnt_lsu = lsu_valid & (~ifu_valid | ~r_rr_ptr);
    w_gnt_ifu = ifu_valid & ~w_gnt_lsu;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= w_gnt_lsu;
    end
  end
`else
  always_comb begin
    w_gnt_lsu = lsu_valid;
    w_gnt_ifu = ifu_valid & ~lsu_valid;
  end
`endif

  always_comb begin
    w_idle         = (r_state == c_st_idle) & ~reset;
    w_accept       = w_idle & (w_gnt_lsu | w_gnt_ifu);
    w_lsu_misalign = ((lsu_mask == 2'b10) & lsu_addr[0]) |
                     ((lsu_mask == 2'b11) & (|lsu_addr[1:0]));
    w_ifu_misalign = |ifu_addr[1:0];
    w_misaligned   = w_gnt_lsu ? w_lsu_misalign : w_ifu_misalign;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; misaligned requests skip the memory entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_accept)   w_state_nxt = w_misaligned ? c_st_resp : c_st_issue;
      c_st_issue: if (mem_ready)  w_state_nxt = c_st_wait;
      c_st_wait:  if (mem_rvalid) w_state_nxt = c_st_resp;
      c_st_resp:                  w_state_nxt = c_st_idle;
      default:                    w_state_nxt = c_st_idle;
    endcase
  end

  // Request is captured once at grant and held until the response has been delivered
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner <= c_own_ifu;
      r_addr  <= 32'd0;
      r_write <= 1'b0;
      r_wdata <= 32'd0;
      r_mask  <= 2'b00;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_owner <= w_gnt_lsu ? c_own_lsu : c_own_ifu;
      r_addr  <= w_gnt_lsu ? lsu_addr : ifu_addr;
      r_write <= w_gnt_lsu & lsu_write;
      r_wdata <= w_gnt_lsu ? lsu_wdata : 32'd0;
      r_mask  <= w_gnt_lsu ? lsu_mask : 2'b11;
      r_rdata <= 32'd0;
      r_err   <= w_misaligned;
    end else if ((r_state == c_st_wait) && mem_rvalid) begin
      r_rdata <= mem_rdata;
      r_err   <= |mem_resp;
    end
  end

  // Output logic; everything is forced low while reset is asserted
  always_comb begin
    case (r_mask)
      2'b01:   w_strb_base = 4'b0001;
      2'b10:   w_strb_base = 4'b0011;
      2'b11:   w_strb_base = 4'b1111;
      default: w_strb_base = 4'b0000;
    endcase

    ifu_ready  = w_idle & w_gnt_ifu;
    lsu_ready  = w_idle & w_gnt_lsu;

    mem_valid  = (r_state == c_st_issue) & ~reset;
    mem_write  = mem_valid & r_write;
    mem_addr   = mem_valid ? r_addr : 32'd0;
    mem_wdata  = mem_valid ? (r_wdata << {r_addr[1:0], 3'b000}) : 32'd0;
    mem_wstrb  = mem_valid ? (w_strb_base << r_addr[1:0]) : 4'b0000;

    w_resp     = (r_state == c_st_resp) & ~reset;
    ifu_rvalid = w_resp & (r_owner == c_own_ifu);
    lsu_rvalid = w_resp & (r_owner == c_own_lsu);
    ifu_rdata  = ifu_rvalid ? r_rdata : 32'd0;
    ifu_err    = ifu_rvalid & r_err;
    lsu_rdata  = lsu_rvalid ? r_rdata : 32'd0;
    lsu_err    = lsu_rvalid & r_err;
  end

endmodule
`default_nettype wire
